// File: rtl/airi5c_fetch_buffer.sv
// Instruction prefetch queue: issues word fetches, buffers {word, pc, err}, feeds decode in order. Optional macro: FETCH_BUF_BYPASS_EN.
// Latency: a response reaches decode the cycle after imem_rsp_valid (same cycle with FETCH_BUF_BYPASS_EN when the queue is empty).
// Backpressure: requests only while count + outstanding < DEPTH; a decode stall holds the head entry stable.
module airi5c_fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        rsp_entry;
  entry_t        head;
  entry_t        sel;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW:0]   occupancy;
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic          rsp_live;
  logic          req_fire;
  logic          bypass;
  logic          push;
  logic          pop;

  // A response is live when no stale (pre-redirect) responses remain to be discarded.
  assign rsp_live  = imem_rsp_valid && (drop == '0);
  assign rsp_entry = '{dat: (imem_rsp_err ? NOP : imem_rsp_data), pc: resp_pc, err: imem_rsp_err};

  // Credit rule: entries held plus requests in flight never exceed the storage, so no overflow.
  assign occupancy      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !redirect && (occupancy < DEPTH_W);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = (count == '0) && rsp_live && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = (count != '0) && inst_ready && !redirect;
  assign push = rsp_live && !redirect && !(bypass && inst_ready);

  // Decode-side view: head entry (or bypassed response), zeroed while nothing is valid.
  always_comb begin
    head       = mem[rd_ptr];
    sel        = bypass ? rsp_entry : head;
    inst_valid = (count != '0) || bypass;
    inst       = '0;
    inst_pc    = '0;
    inst_err   = 1'b0;
    if (inst_valid) begin
      inst     = sel.dat;
      inst_pc  = sel.pc;
      inst_err = sel.err;
    end
  end

  // Entry storage; no reset needed because outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rsp_entry;
    end
  end

  // Control state: redirect overrides request, response and pop bookkeeping in its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      resp_pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      // Everything still in flight becomes stale; a response arriving now is already retired.
      drop        <= drop + outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc <= pc + 32'd4;
      end
      if (rsp_live) begin
        resp_pc <= resp_pc + 32'd4;
      end
      if (imem_rsp_valid && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
    end
  end

endmodule

// File: tb/tb_airi5c_fetch_buffer.sv
// Directed bench for airi5c_fetch_buffer (DEPTH=2, default build without response bypass).
// Each table row is one clock cycle: inputs driven after the falling edge, outputs compared 1 ns later.
// Asynchronous reset with requests outstanding is exercised by a hand-written sequence at the end.
module tb_airi5c_fetch_buffer;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  int errors = 0;
  int checks = 0;

  airi5c_fetch_buffer #(.DEPTH(2), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst;
    logic        rq_rdy;
    logic        rs_vld;
    logic [31:0] rs_dat;
    logic        rs_err;
    logic        redir;
    logic [31:0] redir_pc;
    logic        i_rdy;
    logic        e_rq_vld;
    logic [31:0] e_addr;
    logic        e_i_vld;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic rq_rdy, input logic rs_vld, input logic [31:0] rs_dat,
    input logic rs_err, input logic redir, input logic [31:0] redir_pc, input logic i_rdy,
    input logic e_rq_vld, input logic [31:0] e_addr, input logic e_i_vld,
    input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_err);
    vec_t v;
    v.rst = rst; v.rq_rdy = rq_rdy; v.rs_vld = rs_vld; v.rs_dat = rs_dat;
    v.rs_err = rs_err; v.redir = redir; v.redir_pc = redir_pc; v.i_rdy = i_rdy;
    v.e_rq_vld = e_rq_vld; v.e_addr = e_addr; v.e_i_vld = e_i_vld;
    v.e_inst = e_inst; v.e_pc = e_pc; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic e_rq_vld, input logic [31:0] e_addr,
                             input logic e_i_vld, input logic [31:0] e_inst,
                             input logic [31:0] e_pc, input logic e_err);
    chk({tag, " req_valid"}, {31'b0, imem_req_valid}, {31'b0, e_rq_vld});
    chk({tag, " req_addr"},  imem_req_addr, e_addr);
    chk({tag, " inst_valid"}, {31'b0, inst_valid}, {31'b0, e_i_vld});
    chk({tag, " inst"},      inst, e_inst);
    chk({tag, " inst_pc"},   inst_pc, e_pc);
    chk({tag, " inst_err"},  {31'b0, inst_err}, {31'b0, e_err});
  endtask

  vec_t tv[$];

  localparam logic [31:0] D0 = 32'h0010_0093, D1 = 32'h0020_0113, DE = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h0030_0193, D4 = 32'h0040_0213, D5 = 32'h0050_0293;
  localparam logic [31:0] D6 = 32'h0060_0313, D8 = 32'h0070_0393, NOP = 32'h0000_0013;

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    imem_rsp_err = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    //            rst rdy rv  rdata        rerr rd  rd_pc         ird  e_rv e_addr         e_iv e_inst e_pc           e_err
    // reset state
    tv.push_back(mk(1, 0, 0, 32'h0,        0,  0, 32'h0,         0,   0, 32'h8000_0000, 0, 32'h0, 32'h0,         0));
    // request held stable while memory is not ready
    tv.push_back(mk(0, 0, 0, 32'h0,        0,  0, 32'h0,         1,   1, 32'h8000_0000, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1,   1, 32'h8000_0000, 0, 32'h0, 32'h0,         0));
    // streaming with 1-cycle memory; response visible next cycle
    tv.push_back(mk(0, 1, 1, D0,           0,  0, 32'h0,         1,   1, 32'h8000_0004, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 1, D1,           0,  0, 32'h0,         1,   0, 32'h8000_0008, 1, D0,    32'h8000_0000, 0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1,   1, 32'h8000_0008, 1, D1,    32'h8000_0004, 0));
    // bus error at 0x8000_0008 becomes NOP with err set
    tv.push_back(mk(0, 1, 1, DE,           1,  0, 32'h0,         1,   1, 32'h8000_000C, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 1, D3,           0,  0, 32'h0,         1,   0, 32'h8000_0010, 1, NOP,   32'h8000_0008, 1));
    // decode stalls: queue fills to DEPTH, requests stop, head held
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         0,   1, 32'h8000_0010, 1, D3,    32'h8000_000C, 0));
    tv.push_back(mk(0, 1, 1, D4,           0,  0, 32'h0,         0,   0, 32'h8000_0014, 1, D3,    32'h8000_000C, 0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         0,   0, 32'h8000_0014, 1, D3,    32'h8000_000C, 0));
    // release: in-order drain, then fetch resumes
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1,   0, 32'h8000_0014, 1, D3,    32'h8000_000C, 0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1,   1, 32'h8000_0014, 1, D4,    32'h8000_0010, 0));
    // two requests outstanding, then redirect to a misaligned target
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1,   1, 32'h8000_0018, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_1002, 1,   0, 32'h8000_001C, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 1, 32'hBAD0_0001, 0, 0, 32'h0,         1,   1, 32'h0000_1000, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 1, 32'hBAD0_0002, 0, 0, 32'h0,         1,   1, 32'h0000_1004, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 1, D5,           0,  0, 32'h0,         1,   0, 32'h0000_1008, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 1, D6,           0,  0, 32'h0,         1,   0, 32'h0000_1008, 1, D5,    32'h0000_1000, 0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1,   1, 32'h0000_1008, 1, D6,    32'h0000_1004, 0));
    // redirect with its in-flight response arriving the same cycle
    tv.push_back(mk(0, 1, 1, 32'hBAD0_0003, 0, 1, 32'h0000_2000, 1,   0, 32'h0000_100C, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1,   1, 32'h0000_2000, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1,   1, 32'h0000_2004, 0, 32'h0, 32'h0,         0));
    // back-to-back redirects accumulate drop
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_3000, 1,   0, 32'h0000_2008, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 1, 32'hBAD0_0004, 0, 1, 32'h0000_4000, 1,   0, 32'h0000_3000, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 1, 32'hBAD0_0005, 0, 0, 32'h0,         1,   1, 32'h0000_4000, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 1, D8,           0,  0, 32'h0,         1,   1, 32'h0000_4004, 0, 32'h0, 32'h0,         0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         0,   0, 32'h0000_4008, 1, D8,    32'h0000_4000, 0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      reset          = tv[i].rst;
      imem_req_ready = tv[i].rq_rdy;
      imem_rsp_valid = tv[i].rs_vld;
      imem_rsp_data  = tv[i].rs_dat;
      imem_rsp_err   = tv[i].rs_err;
      redirect       = tv[i].redir;
      redirect_pc    = tv[i].redir_pc;
      inst_ready     = tv[i].i_rdy;
      #1;
      chk_outputs($sformatf("v%0d", i), tv[i].e_rq_vld, tv[i].e_addr, tv[i].e_i_vld,
                  tv[i].e_inst, tv[i].e_pc, tv[i].e_err);
    end

    // Asynchronous reset mid-cycle with one entry buffered and one request in flight.
    @(negedge clk);
    imem_rsp_valid = 1'b0; redirect = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk_outputs("pre_reset", 1'b0, 32'h0000_4008, 1'b1, D8, 32'h0000_4000, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_outputs("async_reset", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_outputs("post_reset", 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    chk_outputs("post_reset_next", 1'b1, 32'h8000_0004, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
